// File: rtl/sequence_display_module.sv
// sequence_display_module
// Plays a packed Simon colour sequence on the four game LEDs, one step at a
// time, with on/gap durations derived from the latched speed setting.
// Optional feature macro: SEQ_DISPLAY_ACCEL_EN -- when defined, the LED
// on-time shrinks by (on >> 4) cycles per step, floored at 1 cycle.

module sequence_display_module #(
   parameter int unsigned BASE_ON_CYCLES  = 40_000_000,
   parameter int unsigned BASE_GAP_CYCLES = 20_000_000,
   parameter int unsigned MAX_STEPS       = 16
) (
   input  logic                   i_clk,
   input  logic                   i_reset_n,
   input  logic                   i_start,
   input  logic                   i_abort,
   input  logic [1:0]             i_speed,
   input  logic [4:0]             i_length,
   input  logic [2*MAX_STEPS-1:0] i_sequence,
   output logic [3:0]             o_led_color,
   output logic                   o_busy,
   output logic [3:0]             o_step,
   output logic                   o_done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_GAP  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Duration for a speed setting: speeds 2 and 3 both divide by four.
   function automatic logic [31:0] scaled_dur(input logic [31:0] base,
                                              input logic [1:0]  speed);
      logic [31:0] d;
      case (speed)
         2'd0:    d = base;
         2'd1:    d = base >> 1;
         default: d = base >> 2;
      endcase
      if (d == '0) d = 32'd1;
      return d;
   endfunction

`ifdef SEQ_DISPLAY_ACCEL_EN
   // On-time for step k: on - (on >> 4) * k, never below one cycle.
   function automatic logic [31:0] accel_on(input logic [31:0] on,
                                            input logic [3:0]  k);
      logic [35:0] cut;
      cut = {4'd0, (on >> 4)} * {32'd0, k};
      if (cut >= {4'd0, on}) return 32'd1;
      return on - cut[31:0];
   endfunction
`endif

   state_t                 state_q, state_nxt;
   logic [3:0]             step_q, step_nxt;
   logic [31:0]            cnt_q, cnt_nxt;
   logic [2*MAX_STEPS-1:0] seq_q, seq_nxt;
   logic [31:0]            len_q, len_nxt;
   logic [31:0]            on_q, on_nxt;
   logic [31:0]            gap_q, gap_nxt;

   logic [31:0]            start_on, start_gap, start_len;
   logic [31:0]            next_on;
   logic                   last_step;
   logic [1:0]             color_nxt;
   logic [3:0]             led_nxt;
   logic                   busy_nxt;
   logic                   done_nxt;

   // Start-time values computed straight from the live inputs.
   always_comb begin
      start_on  = scaled_dur(32'(BASE_ON_CYCLES), i_speed);
      start_gap = scaled_dur(32'(BASE_GAP_CYCLES), i_speed);
      start_len = (32'(i_length) > MAX_STEPS) ? 32'(MAX_STEPS) : 32'(i_length);
      last_step = ((32'(step_q) + 32'd1) >= len_q);
`ifdef SEQ_DISPLAY_ACCEL_EN
      next_on   = accel_on(on_q, step_q + 4'd1);
`else
      next_on   = on_q;
`endif
   end

   // Next-state, counter and latch logic; abort overrides everything else.
   always_comb begin
      state_nxt = state_q;
      step_nxt  = step_q;
      cnt_nxt   = cnt_q;
      seq_nxt   = seq_q;
      len_nxt   = len_q;
      on_nxt    = on_q;
      gap_nxt   = gap_q;

      case (state_q)
         S_IDLE: begin
            if (i_start && !i_abort) begin
               seq_nxt  = i_sequence;
               len_nxt  = start_len;
               on_nxt   = start_on;
               gap_nxt  = start_gap;
               step_nxt = '0;
               if (start_len == '0) begin
                  state_nxt = S_DONE;
               end else begin
                  state_nxt = S_ON;
                  cnt_nxt   = start_on - 32'd1;
               end
            end
         end
         S_ON: begin
            if (cnt_q == '0) begin
               state_nxt = S_GAP;
               cnt_nxt   = gap_q - 32'd1;
            end else begin
               cnt_nxt = cnt_q - 32'd1;
            end
         end
         S_GAP: begin
            if (cnt_q == '0) begin
               if (last_step) begin
                  state_nxt = S_DONE;
               end else begin
                  state_nxt = S_ON;
                  step_nxt  = step_q + 4'd1;
                  cnt_nxt   = next_on - 32'd1;
               end
            end else begin
               cnt_nxt = cnt_q - 32'd1;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      if (i_abort && (state_q != S_IDLE)) begin
         state_nxt = S_IDLE;
         cnt_nxt   = '0;
      end
   end

   // Output values for the upcoming state, so the outputs can be registered.
   always_comb begin
      color_nxt = 2'd0;
      for (int unsigned k = 0; k < MAX_STEPS; k++) begin
         if (32'(step_nxt) == k) color_nxt = seq_nxt[2*k +: 2];
      end
      led_nxt  = (state_nxt == S_ON) ? (4'b0001 << color_nxt) : 4'b0000;
      busy_nxt = (state_nxt == S_ON) || (state_nxt == S_GAP);
      done_nxt = (state_nxt == S_DONE);
   end

   // State, latched playback parameters and registered outputs.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q     <= S_IDLE;
         step_q      <= '0;
         cnt_q       <= '0;
         seq_q       <= '0;
         len_q       <= '0;
         on_q        <= '0;
         gap_q       <= '0;
         o_led_color <= '0;
         o_busy      <= 1'b0;
         o_step      <= '0;
         o_done      <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         step_q      <= step_nxt;
         cnt_q       <= cnt_nxt;
         seq_q       <= seq_nxt;
         len_q       <= len_nxt;
         on_q        <= on_nxt;
         gap_q       <= gap_nxt;
         o_led_color <= led_nxt;
         o_busy      <= busy_nxt;
         o_step      <= step_nxt;
         o_done      <= done_nxt;
      end
   end

endmodule

// File: tb/tb_sequence_display_module.sv
// tb_sequence_display_module
// Scoreboard bench: each start pushes the expected per-cycle outputs, and the
// test tasks pop and compare one record per clock.

module tb_sequence_display_module;

`ifdef SEQ_DISPLAY_ACCEL_EN
   localparam int unsigned BASE_ON = 32;
`else
   localparam int unsigned BASE_ON = 8;
`endif
   localparam int unsigned BASE_GAP  = 4;
   localparam int unsigned MAX_STEPS = 16;

   logic        i_clk      = 1'b0;
   logic        i_reset_n  = 1'b0;
   logic        i_start    = 1'b0;
   logic        i_abort    = 1'b0;
   logic [1:0]  i_speed    = '0;
   logic [4:0]  i_length   = '0;
   logic [31:0] i_sequence = '0;
   logic [3:0]  o_led_color;
   logic        o_busy;
   logic [3:0]  o_step;
   logic        o_done;

   typedef struct packed {
      logic [3:0] led;
      logic       busy;
      logic       done;
      logic [3:0] step;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned n_pass  = 0;
   int unsigned n_total = 0;
   int unsigned max_step;

   sequence_display_module #(
      .BASE_ON_CYCLES (BASE_ON),
      .BASE_GAP_CYCLES(BASE_GAP),
      .MAX_STEPS      (MAX_STEPS)
   ) dut (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_start    (i_start),
      .i_abort    (i_abort),
      .i_speed    (i_speed),
      .i_length   (i_length),
      .i_sequence (i_sequence),
      .o_led_color(o_led_color),
      .o_busy     (o_busy),
      .o_step     (o_step),
      .o_done     (o_done)
   );

   always #5 i_clk = ~i_clk;

   function automatic int unsigned model_dur(input int unsigned base, input logic [1:0] speed);
      int unsigned d;
      case (speed)
         2'd0:    d = base;
         2'd1:    d = base / 2;
         default: d = base / 4;
      endcase
      if (d == 0) d = 1;
      return d;
   endfunction

   // Expected outputs from the cycle after the start edge through one idle cycle.
   task automatic push_playback(input logic [31:0] seq, input logic [4:0] len,
                                input logic [1:0] speed);
      int unsigned n, on, gap, on_k;
      logic [1:0]  color;
      exp_t        e;
      n = int'(len);
      if (n > MAX_STEPS) n = MAX_STEPS;
      on  = model_dur(BASE_ON, speed);
      gap = model_dur(BASE_GAP, speed);
      for (int unsigned k = 0; k < n; k++) begin
         on_k = on;
`ifdef SEQ_DISPLAY_ACCEL_EN
         if ((on / 16) * k >= on) on_k = 1;
         else on_k = on - (on / 16) * k;
`endif
         color  = seq[2*k +: 2];
         e.led  = 4'b0001 << color;
         e.busy = 1'b1;
         e.done = 1'b0;
         e.step = 4'(k);
         repeat (on_k) sb_q.push_back(e);
         e.led = 4'b0000;
         repeat (gap) sb_q.push_back(e);
      end
      e.led = 4'b0000; e.busy = 1'b0; e.done = 1'b1; e.step = 4'd0;
      sb_q.push_back(e);
      e.done = 1'b0;
      sb_q.push_back(e);
   endtask

   task automatic next_exp(output exp_t e);
      @(posedge i_clk);
      #1;
      e = sb_q.pop_front();
   endtask

   task automatic test_reset;
      #2;
      n_total++;
      if ({o_led_color, o_busy, o_step, o_done} !== 10'd0)
         $display("FAIL reset_hold: got led=%b busy=%b step=%0d done=%b, expected all 0",
                  o_led_color, o_busy, o_step, o_done);
      else n_pass++;
      @(posedge i_clk); #1;
      i_reset_n = 1'b1;
      @(posedge i_clk); #1;
      n_total++;
      if ({o_led_color, o_busy, o_step, o_done} !== 10'd0)
         $display("FAIL reset_idle: got led=%b busy=%b step=%0d done=%b, expected all 0",
                  o_led_color, o_busy, o_step, o_done);
      else n_pass++;
   endtask

   task automatic test_basic;
      exp_t e, act;
      int unsigned cyc = 0;
      i_sequence = 32'h0000_00e4; i_length = 5'd4; i_speed = 2'd0; i_start = 1'b1;
      push_playback(i_sequence, i_length, i_speed);
      while (sb_q.size() != 0) begin
         next_exp(e);
         cyc++;
         i_start = 1'b0;
         act = {o_led_color, o_busy, o_done, (e.busy ? o_step : e.step)};
         n_total++;
         if (act !== e)
            $display("FAIL basic t+%0d: got led/busy/done/step=%h, expected %h", cyc, act, e);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid;
      exp_t e, act;
      i_sequence = 32'h0000_001b; i_length = 5'd4; i_speed = 2'd0; i_start = 1'b1;
      push_playback(i_sequence, i_length, i_speed);
      repeat (10) begin
         next_exp(e);
         i_start = 1'b0;
         act = {o_led_color, o_busy, o_done, (e.busy ? o_step : e.step)};
         n_total++;
         if (act !== e) $display("FAIL reset_mid_play: got %h, expected %h", act, e);
         else n_pass++;
      end
      sb_q.delete();
      #3;
      i_reset_n = 1'b0;
      #1;
      n_total++;
      if ({o_led_color, o_busy, o_step, o_done} !== 10'd0)
         $display("FAIL reset_async: got led=%b busy=%b step=%0d done=%b, expected all 0",
                  o_led_color, o_busy, o_step, o_done);
      else n_pass++;
      @(posedge i_clk); #1;
      i_reset_n = 1'b1;
      repeat (3) begin
         @(posedge i_clk); #1;
         n_total++;
         if ({o_led_color, o_busy, o_done} !== 6'd0)
            $display("FAIL reset_release: got led=%b busy=%b done=%b, expected 0 0 0",
                     o_led_color, o_busy, o_done);
         else n_pass++;
      end
   endtask

   task automatic test_speed_clamp;
      exp_t e, act;
      i_sequence = 32'h1b6c_93e4; i_length = 5'd20; i_speed = 2'd3; i_start = 1'b1;
      max_step = 0;
      push_playback(i_sequence, i_length, i_speed);
      while (sb_q.size() != 0) begin
         next_exp(e);
         i_start = 1'b0;
         if (o_busy && int'(o_step) > max_step) max_step = int'(o_step);
         act = {o_led_color, o_busy, o_done, (e.busy ? o_step : e.step)};
         n_total++;
         if (act !== e) $display("FAIL speed_clamp: got %h, expected %h", act, e);
         else n_pass++;
      end
      n_total++;
      if (max_step != 15) $display("FAIL clamp_max_step: got %0d, expected 15", max_step);
      else n_pass++;
   endtask

   task automatic test_len0_restart;
      exp_t e, act;
      int unsigned i = 0;
      i_sequence = 32'h0000_00ff; i_length = 5'd0; i_speed = 2'd0; i_start = 1'b1;
      push_playback(i_sequence, i_length, i_speed);
      while (sb_q.size() != 0) begin
         next_exp(e);
         i_start = 1'b0;
         act = {o_led_color, o_busy, o_done, (e.busy ? o_step : e.step)};
         n_total++;
         if (act !== e) $display("FAIL len0: got %h, expected %h", act, e);
         else n_pass++;
      end
      i_sequence = 32'h0000_0027; i_length = 5'd3; i_speed = 2'd1; i_start = 1'b1;
      push_playback(i_sequence, i_length, i_speed);
      while (sb_q.size() != 0) begin
         next_exp(e);
         i++;
         // Stray start pulses while playing must leave the timing untouched.
         i_start = (sb_q.size() > 1) && (i % 5 == 3);
         act = {o_led_color, o_busy, o_done, (e.busy ? o_step : e.step)};
         n_total++;
         if (act !== e) $display("FAIL restart_ignore: got %h, expected %h", act, e);
         else n_pass++;
      end
      i_start = 1'b0;
   endtask

   task automatic test_abort;
      exp_t e, act;
      i_sequence = 32'h0000_00e4; i_length = 5'd4; i_speed = 2'd0; i_start = 1'b1;
      push_playback(i_sequence, i_length, i_speed);
      repeat (2 * model_dur(BASE_ON, 2'd0) + 2 * BASE_GAP + 3) begin
         next_exp(e);
         i_start = 1'b0;
         act = {o_led_color, o_busy, o_done, (e.busy ? o_step : e.step)};
         n_total++;
         if (act !== e) $display("FAIL abort_pre: got %h, expected %h", act, e);
         else n_pass++;
      end
      sb_q.delete();
      i_abort = 1'b1; i_start = 1'b1;
      @(posedge i_clk); #1;
      i_abort = 1'b0; i_start = 1'b0;
      n_total++;
      if ({o_led_color, o_busy, o_done} !== 6'd0)
         $display("FAIL abort_idle: got led=%b busy=%b done=%b, expected 0 0 0",
                  o_led_color, o_busy, o_done);
      else n_pass++;
      repeat (60) begin
         @(posedge i_clk); #1;
         n_total++;
         if ({o_led_color, o_busy, o_done} !== 6'd0)
            $display("FAIL abort_quiet: got led=%b busy=%b done=%b, expected 0 0 0",
                     o_led_color, o_busy, o_done);
         else n_pass++;
      end
      i_sequence = 32'h0000_001e; i_length = 5'd3; i_speed = 2'd2; i_start = 1'b1;
      push_playback(i_sequence, i_length, i_speed);
      while (sb_q.size() != 0) begin
         next_exp(e);
         i_start = 1'b0;
         act = {o_led_color, o_busy, o_done, (e.busy ? o_step : e.step)};
         n_total++;
         if (act !== e) $display("FAIL abort_fresh: got %h, expected %h", act, e);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back;
      exp_t e, act;
      i_sequence = 32'h0000_0039; i_length = 5'd2; i_speed = 2'd1; i_start = 1'b1;
      // Start held high: accepted again one idle cycle after the done pulse.
      push_playback(i_sequence, i_length, i_speed);
      push_playback(i_sequence, i_length, i_speed);
      while (sb_q.size() != 0) begin
         next_exp(e);
         act = {o_led_color, o_busy, o_done, (e.busy ? o_step : e.step)};
         n_total++;
         if (act !== e) $display("FAIL back_to_back: got %h, expected %h", act, e);
         else n_pass++;
      end
      i_start = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_reset_mid();
      test_speed_clamp();
      test_len0_restart();
      test_abort();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
